state_sequencer: RTL and testbench

Upstream stage of the seven-segment display driver. Turns three raw push-buttons into the 3-bit `state` code that the display driver decodes and shows. The block synchronises and debounces each button, then edge-detects it to get a one-cycle press. A wrap-around state counter steps manually on each press, or automatically from a free-running timer while run mode is enabled.

---
 rtl/state_sequencer.sv | 114 +++++++++++
 tb/tb_state_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/state_sequencer.sv
// Button-driven state sequencer feeding the seven-segment display driver.
// Synchronises, debounces and edge-detects three buttons, then steps a wrap-around state code.
module state_sequencer #(
    parameter int DEBOUNCE_W = 20,
    parameter int NUM_STATES = 6,
    parameter int AUTO_W     = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_run,
    output logic [2:0] state,
    output logic       running,
    output logic       state_changed
);
    localparam int NB = 3;
    localparam int B_NEXT = 0;
    localparam int B_PREV = 1;
    localparam int B_RUN  = 2;
    localparam logic [2:0] LAST = 3'(NUM_STATES - 1);
    localparam logic [DEBOUNCE_W-1:0] CNT_MAX = '1;

    logic [NB-1:0]         sync1_q, sync1_d;
    logic [NB-1:0]         sync2_q, sync2_d;
    logic [NB-1:0]         deb_q, deb_d;
    logic [NB-1:0]         deb_prev_q, deb_prev_d;
    logic [DEBOUNCE_W-1:0] cnt_q [NB];
    logic [DEBOUNCE_W-1:0] cnt_d [NB];
    logic [NB-1:0]         press;

    logic [2:0]            state_q, state_d;
    logic                  running_q, running_d;
    logic                  changed_q, changed_d;
    logic [AUTO_W-1:0]     timer_q, timer_d;
    logic                  do_next, do_prev, expiry;

    function automatic logic [2:0] step_up(input logic [2:0] s);
        return (s == LAST) ? 3'd0 : s + 3'd1;
    endfunction

    function automatic logic [2:0] step_down(input logic [2:0] s);
        return (s == 3'd0) ? LAST : s - 3'd1;
    endfunction

    always_comb begin
        sync1_d    = {btn_run, btn_prev, btn_next};
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            // Count only unbroken mismatch; the level flips once the count saturates.
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) deb_d[i] = sync2_q[i];
                else                     cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
            end
        end
        press = deb_q & ~deb_prev_q;
    end

    always_comb begin
        state_d   = state_q;
        running_d = running_q ^ press[B_RUN];
        timer_d   = timer_q;
        do_next   = press[B_NEXT] & ~press[B_PREV];
        do_prev   = press[B_PREV] & ~press[B_NEXT];
        expiry    = running_q & (&timer_q);
        // Manual presses override an expiring timer; a run press suppresses the auto step.
        if (press[B_NEXT] | press[B_PREV]) begin
            timer_d = '0;
            if (do_next)      state_d = step_up(state_q);
            else if (do_prev) state_d = step_down(state_q);
        end else if (press[B_RUN]) begin
            timer_d = '0;
        end else if (expiry) begin
            state_d = step_up(state_q);
            timer_d = '0;
        end else if (running_q) begin
            timer_d = timer_q + AUTO_W'(1);
        end else begin
            timer_d = '0;
        end
        changed_d = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
            state_q    <= '0;
            running_q  <= 1'b0;
            changed_q  <= 1'b0;
            timer_q    <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
            state_q    <= state_d;
            running_q  <= running_d;
            changed_q  <= changed_d;
            timer_q    <= timer_d;
        end
    end

    assign state         = state_q;
    assign running       = running_q;
    assign state_changed = changed_q;
endmodule

// File: tb/tb_state_sequencer.sv
// Scoreboard bench for state_sequencer: stimulus queues expected state_changed pulses
// (value and cycle), a forked monitor pops and compares each pulse as it appears.
module tb_state_sequencer;
    localparam int DW  = 4;
    localparam int AW  = 6;
    localparam int NS  = 6;
    localparam int LAT = (1 << DW) + 3;   // drive cycle -> state update edge
    localparam int AUTO_P = 1 << AW;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       btn_run = 1'b0;
    logic [2:0] state;
    logic       running;
    logic       state_changed;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int r;

    typedef struct {
        logic [2:0] st;
        int         at;
    } exp_t;
    exp_t sb[$];

    state_sequencer #(.DEBOUNCE_W(DW), .NUM_STATES(NS), .AUTO_W(AW)) dut (
        .clk(clk),
        .reset(reset),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .btn_run(btn_run),
        .state(state),
        .running(running),
        .state_changed(state_changed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input logic [2:0] st, input int at);
        exp_t e;
        e.st = st;
        e.at = at;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        logic [2:0] last_state;
        last_state = 3'd0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                last_state = 3'd0;
            end else begin
                if (state_changed === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse state=%0d cyc=%0d want no pulse", state, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("pulse_state", int'(state), int'(e.st));
                        check("pulse_cycle", cyc, e.at);
                    end
                end
                if (state !== last_state && state_changed !== 1'b1) begin
                    checks++;
                    errors++;
                    $display("FAIL silent_change state=%0d prev=%0d cyc=%0d want pulse", state, last_state, cyc);
                end
                last_state = state;
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        wait_cyc(3);
        check("rst_state", int'(state), 0);
        check("rst_running", int'(running), 0);
        check("rst_changed", int'(state_changed), 0);
        reset = 1'b1;
        wait_cyc(2);

        // single next press, long hold, release does nothing
        btn_next = 1'b1;
        expect_pulse(3'd1, cyc + LAT);
        wait_cyc(40);
        btn_next = 1'b0;
        wait_cyc(40);
        check("t1_queue_empty", sb.size(), 0);
        check("t1_state", int'(state), 1);

        // too-short press is filtered
        btn_next = 1'b1;
        wait_cyc(10);
        btn_next = 1'b0;
        wait_cyc(40);
        check("t2_state", int'(state), 1);

        // prev 1->0, prev wraps 0->5, next wraps 5->0
        btn_prev = 1'b1;
        expect_pulse(3'd0, cyc + LAT);
        wait_cyc(30);
        btn_prev = 1'b0;
        wait_cyc(30);
        btn_prev = 1'b1;
        expect_pulse(3'd5, cyc + LAT);
        wait_cyc(30);
        btn_prev = 1'b0;
        wait_cyc(30);
        check("t3_state_wrap_down", int'(state), 5);
        btn_next = 1'b1;
        expect_pulse(3'd0, cyc + LAT);
        wait_cyc(30);
        btn_next = 1'b0;
        wait_cyc(30);
        check("t3_state_wrap_up", int'(state), 0);

        // simultaneous next+prev cancels
        btn_next = 1'b1;
        btn_prev = 1'b1;
        wait_cyc(40);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        wait_cyc(40);
        check("t4_state", int'(state), 0);
        check("t4_queue_empty", sb.size(), 0);

        // run mode: auto steps every AUTO_P cycles, manual press on expiry cycle
        btn_run = 1'b1;
        r = cyc + LAT;
        expect_pulse(3'd1, r + AUTO_P);
        expect_pulse(3'd2, r + 2 * AUTO_P);
        expect_pulse(3'd3, r + 3 * AUTO_P);
        expect_pulse(3'd4, r + 4 * AUTO_P);
        wait_cyc(20);
        btn_run = 1'b0;
        check("t5_running", int'(running), 1);
        wait_cyc(r + 3 * AUTO_P - LAT - cyc);
        btn_next = 1'b1;
        wait_cyc(25);
        btn_next = 1'b0;
        wait_cyc(r + 4 * AUTO_P + 14 - cyc);
        check("t5_queue_empty", sb.size(), 0);
        check("t5_state", int'(state), 4);

        // reset mid-run with next held; held button re-registers after release
        btn_next = 1'b1;
        wait_cyc(10);
        reset = 1'b0;
        #1;
        check("t6_rst_state", int'(state), 0);
        check("t6_rst_running", int'(running), 0);
        check("t6_rst_changed", int'(state_changed), 0);
        wait_cyc(3);
        reset = 1'b1;
        expect_pulse(3'd1, cyc + LAT);
        wait_cyc(40);
        btn_next = 1'b0;
        check("t6_running", int'(running), 0);
        wait_cyc(2 * AUTO_P);
        check("t6_state", int'(state), 1);
        check("t6_queue_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
